ternary_popcount_acc: RTL and testbench



---
 rtl/tpa_pkg.sv | 36 +++
 rtl/tpa_popcount.sv | 44 ++++
 rtl/ternary_popcount_acc.sv | 125 ++++++++++++
 tb/tb_ternary_popcount_acc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tpa_pkg.sv
// Shared types and helpers for the ternary popcount accumulator: FSM states,
// width helpers, exact popcount and saturating signed add.
package tpa_pkg;

  typedef enum logic {
    IDLE,
    ACC
  } tpa_state_e;

  // Widest beat the popcount helper accepts.
  localparam int MAX_W = 256;

  function automatic int cw_of(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int aw_of(input int w, input int beats);
    return $clog2(w * beats + 1) + 1;
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_W; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/tpa_popcount.sv
// W-input combinational bit counter. Defining TPA_APPROX_EN selects the
// pairwise approximate count (at most 1 below exact, never above).
module tpa_popcount
  import tpa_pkg::*;
#(
  parameter  int W  = 9,
  localparam int CW = cw_of(W)
) (
  input  logic [W-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

`ifdef TPA_APPROX_EN
  localparam int PW = 2 * ((W + 1) / 2);

  logic [PW-1:0] pad;
  int            s_and;
  int            s_xor;
  int            approx;

  // NOTE: every variable driven here gets a value before any conditional use,
  // so no latch is inferred.
  always_comb begin
    pad    = PW'(bits_i);
    s_and  = 0;
    s_xor  = 0;
    for (int i = 0; i < PW; i += 2) begin
      s_and += int'(pad[i] & pad[i+1]);
      s_xor += int'(pad[i] ^ pad[i+1]);
    end
    // Pair LSBs are merged without their carry into bit 1.
    approx = 2 * (s_and + (s_xor >> 1));
    cnt_o  = approx[CW-1:0];
  end
`else
  int exact;

  always_comb begin
    exact = popcount(MAX_W'(bits_i));
    cnt_o = exact[CW-1:0];
  end
`endif

endmodule

// File: rtl/ternary_popcount_acc.sv
// Streaming ternary neuron core: per-beat popcount(pos)-popcount(neg) summed
// over a frame, with saturation and threshold. TPA_APPROX_EN picks approx counts.
module ternary_popcount_acc
  import tpa_pkg::*;
#(
  parameter  int W        = 9,
  parameter  int MAXBEATS = 16,
  localparam int CW       = cw_of(W),
  localparam int AW       = aw_of(W, MAXBEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_pos,
  input  logic [W-1:0]         in_neg,
  input  logic                 in_last,
  input  logic signed [AW-1:0] thr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic                 out_act,
  output logic                 out_ovf
);

  localparam int BW  = $clog2(MAXBEATS + 1);
  localparam int LIM = W * MAXBEATS;

  logic [CW-1:0] cp_d, cn_d;

  tpa_popcount #(.W(W)) u_pop_pos (.bits_i(in_pos), .cnt_o(cp_d));
  tpa_popcount #(.W(W)) u_pop_neg (.bits_i(in_neg), .cnt_o(cn_d));

  logic                 s1_valid_q, s1_last_q, s1_first_q, first_q;
  logic [CW-1:0]        s1_cp_q, s1_cn_q;
  logic signed [AW-1:0] s1_thr_q, thr_frame_q, acc_q;
  tpa_state_e           state_q;
  logic [BW-1:0]        beats_q, beats_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_act_q, out_ovf_q;
  logic signed [AW-1:0] out_sum_q;

  logic                 s1_advance, accept, s2_fire, starting;
  logic signed [AW-1:0] acc_d, thr_eff;
  int                   base_i, delta_i, acc_next_i;

  always_comb begin
    s1_advance = !(s1_valid_q && s1_last_q && out_valid_q && !out_ready);
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;
    s2_fire    = s1_valid_q && s1_advance;
    starting   = (state_q == IDLE);
    base_i     = starting ? 0 : int'(acc_q);
    delta_i    = int'(s1_cp_q) - int'(s1_cn_q);
    acc_next_i = sat_add(base_i, delta_i, LIM);
    acc_d      = acc_next_i[AW-1:0];
    thr_eff    = s1_first_q ? s1_thr_q : thr_frame_q;
    ovf_d      = !starting && (ovf_q || (beats_q == BW'(MAXBEATS)));
    if (starting)                       beats_d = BW'(1);
    else if (beats_q == BW'(MAXBEATS))  beats_d = beats_q;
    else                                beats_d = beats_q + BW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so it is simply the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_cp_q     <= '0;
      s1_cn_q     <= '0;
      s1_thr_q    <= '0;
      first_q     <= 1'b1;
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      thr_frame_q <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_act_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_cp_q    <= cp_d;
        s1_cn_q    <= cn_d;
        s1_last_q  <= in_last;
        s1_first_q <= first_q;
        first_q    <= in_last;
        if (first_q) s1_thr_q <= thr;
      end else if (s2_fire) begin
        s1_valid_q <= 1'b0;
      end

      if (out_ready) out_valid_q <= 1'b0;

      if (s2_fire) begin
        if (s1_last_q) begin
          state_q     <= IDLE;
          acc_q       <= acc_d;
          beats_q     <= '0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_act_q   <= (acc_d >= thr_eff);
          out_ovf_q   <= ovf_d;
        end else begin
          state_q <= ACC;
          acc_q   <= acc_d;
          beats_q <= beats_d;
          ovf_q   <= ovf_d;
          if (s1_first_q) thr_frame_q <= s1_thr_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_act   = out_act_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ternary_popcount_acc.sv
// Directed bench for ternary_popcount_acc (exact build): W=9 with MAXBEATS=16
// on the main instance and MAXBEATS=2 on a second instance for saturation.
module tb_ternary_popcount_acc;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_last, out_ready;
  logic [8:0]        in_pos, in_neg;
  logic signed [8:0] thr;
  logic signed [5:0] thr2;
  logic              in_ready, out_valid, out_act, out_ovf;
  logic signed [8:0] out_sum;
  logic              in_ready2, out_valid2, out_act2, out_ovf2;
  logic signed [5:0] out_sum2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ternary_popcount_acc #(.W(9), .MAXBEATS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last), .thr(thr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_act(out_act), .out_ovf(out_ovf)
  );

  ternary_popcount_acc #(.W(9), .MAXBEATS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last), .thr(thr2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_act(out_act2), .out_ovf(out_ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [8:0] pos, input logic [8:0] neg, input logic last,
                           input logic signed [8:0] t, input logic signed [5:0] t2);
    int n;
    n = 0;
    in_valid = 1'b1; in_pos = pos; in_neg = neg; in_last = last; thr = t; thr2 = t2;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_beat: in_ready got 0, required 1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: out_valid got 0, required 1 within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 9'sd0) begin n_fail++; $display("FAIL reset out_sum: got %0d want 0", out_sum); end
    n_checks++; if (out_act !== 1'b0) begin n_fail++; $display("FAIL reset out_act: got %b want 0", out_act); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset out_ovf: got %b want 0", out_ovf); end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    send_beat(9'h1FF, 9'h000, 1'b1, 9'sd5, 6'sd0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single latency t+1: out_valid got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single latency t+2: out_valid got %b want 1", out_valid); end
    n_checks++; if (out_sum !== 9'sd9) begin n_fail++; $display("FAIL single sum: got %0d want 9", out_sum); end
    n_checks++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL single act: got %b want 1", out_act); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL single ovf: got %b want 0", out_ovf); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single consumed: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_multi_beat();
    // Later beats carry a different threshold that must be ignored.
    send_beat(9'h007, 9'h000, 1'b0, 9'sd0, 6'sd0);
    send_beat(9'h000, 9'h0FF, 1'b0, -9'sd5, 6'sd0);
    send_beat(9'h1F0, 9'h001, 1'b1, -9'sd5, 6'sd0);
    wait_valid("multi");
    n_checks++; if (out_sum !== -9'sd1) begin n_fail++; $display("FAIL multi sum: got %0d want -1", out_sum); end
    n_checks++; if (out_act !== 1'b0) begin n_fail++; $display("FAIL multi act: got %b want 0", out_act); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL multi ovf: got %b want 0", out_ovf); end
    tick();
    // Equal to a negative threshold activates.
    send_beat(9'h000, 9'h00F, 1'b1, -9'sd4, 6'sd0);
    wait_valid("neg_thr");
    n_checks++; if (out_sum !== -9'sd4) begin n_fail++; $display("FAIL neg_thr sum: got %0d want -4", out_sum); end
    n_checks++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL neg_thr act: got %b want 1", out_act); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0]        pos_v [3] = '{9'h001, 9'h003, 9'h007};
    logic signed [8:0] exp_s [3] = '{9'sd1, 9'sd2, 9'sd3};
    logic              exp_a [3] = '{1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_pos = pos_v[i]; in_neg = 9'h000; in_last = 1'b1; thr = 9'sd2;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready[%0d]: got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 3) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b valid[%0d]: got %b want 1", i - 1, out_valid); end
        n_checks++; if (out_sum !== exp_s[i-1]) begin n_fail++; $display("FAIL b2b sum[%0d]: got %0d want %0d", i - 1, out_sum, exp_s[i-1]); end
        n_checks++; if (out_act !== exp_a[i-1]) begin n_fail++; $display("FAIL b2b act[%0d]: got %b want %b", i - 1, out_act, exp_a[i-1]); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drained: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(9'h00F, 9'h000, 1'b1, 9'sd0, 6'sd0);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'sd4) begin n_fail++; $display("FAIL bp first: valid %b sum %0d, want 1 and 4", out_valid, out_sum); end
    in_valid = 1'b1; in_pos = 9'h003; in_neg = 9'h001; in_last = 1'b1; thr = 9'sd0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp accept second: in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp stall: in_ready got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp stall hold: in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'sd4) begin n_fail++; $display("FAIL bp hold: valid %b sum %0d, want 1 and 4", out_valid, out_sum); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'sd1) begin n_fail++; $display("FAIL bp second: valid %b sum %0d, want 1 and 1", out_valid, out_sum); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp no dup: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    // Exactly MAXBEATS beats on the small instance: no overflow.
    send_beat(9'h1FF, 9'h000, 1'b0, 9'sd0, 6'sd0);
    send_beat(9'h1FF, 9'h000, 1'b1, 9'sd0, 6'sd0);
    wait_valid("ovf_edge");
    n_checks++; if (out_sum2 !== 6'sd18) begin n_fail++; $display("FAIL ovf_edge sum2: got %0d want 18", out_sum2); end
    n_checks++; if (out_ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovf_edge ovf2: got %b want 0", out_ovf2); end
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++)
        send_beat(f == 0 ? 9'h1FF : 9'h000, f == 0 ? 9'h000 : 9'h1FF, b == 2, 9'sd0, 6'sd0);
      wait_valid("ovf");
      n_checks++; if (out_sum2 !== (f == 0 ? 6'sd18 : -6'sd18)) begin n_fail++; $display("FAIL ovf[%0d] sum2: got %0d want %0d", f, out_sum2, f == 0 ? 18 : -18); end
      n_checks++; if (out_ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf[%0d] ovf2: got %b want 1", f, out_ovf2); end
      n_checks++; if (out_act2 !== (f == 0)) begin n_fail++; $display("FAIL ovf[%0d] act2: got %b want %b", f, out_act2, f == 0); end
      n_checks++; if (out_sum !== (f == 0 ? 9'sd27 : -9'sd27)) begin n_fail++; $display("FAIL ovf[%0d] wide sum: got %0d want %0d", f, out_sum, f == 0 ? 27 : -27); end
      n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf[%0d] wide ovf: got %b want 0", f, out_ovf); end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    send_beat(9'h1FF, 9'h000, 1'b0, 9'sd0, 6'sd0);
    send_beat(9'h1FF, 9'h000, 1'b0, 9'sd0, 6'sd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    send_beat(9'h003, 9'h000, 1'b1, 9'sd0, 6'sd0);
    wait_valid("midrst");
    n_checks++; if (out_sum !== 9'sd2) begin n_fail++; $display("FAIL midrst sum: got %0d want 2", out_sum); end
    n_checks++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL midrst act: got %b want 1", out_act); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst ovf: got %b want 0", out_ovf); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_pos = '0; in_neg = '0; thr = '0; thr2 = '0;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
